// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit imem words from address 0.
// Define CHECKSUM_EN to add a 4-byte trailer checksum check after the last word.
module imem_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  abort,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic                  cpu_hold,
  output logic                  chk_err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CAP = CW'(1) << ADDR_WIDTH;

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, COLLECT, WRITE, CHECK, DONE
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, COLLECT, WRITE, DONE
  } state_e;
`endif

  state_e                  state_q, state_d;
  logic [1:0]              bcnt_q, bcnt_d;
  logic [23:0]             buf_q, buf_d;
  logic [CW-1:0]           widx_q, widx_d;
  logic [CW-1:0]           total_q, total_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    lerr_q, lerr_d;
  logic                    accept;
`ifdef CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic                    cerr_q, cerr_d;
`endif

  assign accept = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    buf_d   = buf_q;
    widx_d  = widx_q;
    total_d = total_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lerr_d  = lerr_q;
`ifdef CHECKSUM_EN
    sum_d   = sum_q;
    cerr_d  = cerr_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lerr_d  = num_words > CAP;
          total_d = lerr_d ? CAP : num_words;
          widx_d  = '0;
          bcnt_d  = '0;
`ifdef CHECKSUM_EN
          sum_d   = '0;
          cerr_d  = 1'b0;
`endif
          state_d = (total_d == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (abort) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end else if (accept) begin
          buf_d  = {buf_q[15:0], byte_in};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wdata_d = {buf_q, byte_in};
            addr_d  = widx_q[ADDR_WIDTH-1:0];
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          widx_d = widx_q + CW'(1);
`ifdef CHECKSUM_EN
          sum_d   = sum_q + wdata_q;
          state_d = (widx_d == total_q) ? CHECK : COLLECT;
`else
          state_d = (widx_d == total_q) ? DONE : COLLECT;
`endif
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end else if (accept) begin
          buf_d  = {buf_q[15:0], byte_in};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            cerr_d  = {buf_q, byte_in} != sum_q;
            state_d = DONE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      buf_q   <= '0;
      widx_q  <= '0;
      total_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lerr_q  <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q   <= '0;
      cerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      buf_q   <= buf_d;
      widx_q  <= widx_d;
      total_q <= total_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lerr_q  <= lerr_d;
`ifdef CHECKSUM_EN
      sum_q   <= sum_d;
      cerr_q  <= cerr_d;
`endif
    end
  end

  // an abort landing on the strobe cycle suppresses the write
  assign mem_we    = (state_q == WRITE) && !abort;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = state_q == DONE;
  assign len_err   = lerr_q;
`ifdef CHECKSUM_EN
  assign byte_ready = (state_q == COLLECT) || (state_q == CHECK);
  assign busy       = (state_q == COLLECT) || (state_q == WRITE) ||
                      (state_q == CHECK);
  assign chk_err    = cerr_q;
  assign cpu_hold   = !((state_q == DONE) && !cerr_q);
`else
  assign byte_ready = state_q == COLLECT;
  assign busy       = (state_q == COLLECT) || (state_q == WRITE);
  assign chk_err    = 1'b0;
  assign cpu_hold   = state_q != DONE;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against a word-list reference model.
// Build with CHECKSUM_EN defined to also exercise the trailer check.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] num_words = '0;
  logic        abort = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        len_err;
  logic        cpu_hold;
  logic        chk_err;

  int vectors = 0;
  int miscompares = 0;

  logic [12:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] exp_q[$];

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .len_err(len_err),
    .cpu_hold(cpu_hold), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  task automatic do_start(input int n);
    wa.delete();
    wd.delete();
    num_words = 14'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps,
                           output bit ok);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    byte_valid = 1'b1;
    byte_in = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Streams exp_q (plus a trailer equal to the word sum + delta) and waits for done.
  task automatic run_load(input int n, input bit gaps,
                          input logic [31:0] delta, output bit ok);
    logic [31:0] w;
    logic [31:0] sum;
    bit b_ok;
    ok = 1'b1;
    sum = delta;
    do_start(n);
    foreach (exp_q[i]) begin
      w = exp_q[i];
      sum = sum + w;
      for (int k = 0; k < 4; k++) begin
        send_byte(w[31-8*k -: 8], gaps, b_ok);
        ok = ok & b_ok;
      end
    end
`ifdef CHECKSUM_EN
    for (int k = 0; k < 4; k++) begin
      send_byte(sum[31-8*k -: 8], gaps, b_ok);
      ok = ok & b_ok;
    end
`endif
    wait_done(b_ok);
    ok = ok & b_ok;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({byte_ready, mem_we, mem_addr, mem_wdata, busy, done, len_err,
         chk_err, cpu_hold} !== {52'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset: ready=%b we=%b addr=%h data=%h busy=%b done=%b lerr=%b cerr=%b hold=%b, want all 0 and hold=1",
               byte_ready, mem_we, mem_addr, mem_wdata, busy, done,
               len_err, chk_err, cpu_hold);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load(input string nm, input int n, input bit gaps,
                           input bit directed);
    bit ok;
    exp_q.delete();
    if (directed) begin
      exp_q.push_back(32'h8C010004);
      exp_q.push_back(32'h20020005);
    end else begin
      for (int i = 0; i < n; i++) exp_q.push_back($urandom);
    end
    run_load(n, gaps, 32'd0, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_timeout: stream or done did not complete", nm);
    end
    vectors++;
    if (wa.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d writes, want %0d", nm, wa.size(),
               exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < wa.size()) begin
        vectors++;
        if (wa[i] !== 13'(i) || wd[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL %s_write%0d: got %h@%h, want %h@%h", nm, i,
                   wd[i], wa[i], exp_q[i], 13'(i));
        end
      end
    end
    vectors++;
    if ({done, cpu_hold, busy, len_err, chk_err} !== 5'b10000) begin
      miscompares++;
      $display("FAIL %s_status: done/hold/busy/lerr/cerr=%b, want 10000",
               nm, {done, cpu_hold, busy, len_err, chk_err});
    end
  endtask

  task automatic test_abort;
    bit ok;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back($urandom);
    do_start(3);
    for (int k = 0; k < 6; k++) begin
      send_byte(exp_q[k/4][31-8*(k%4) -: 8], 1'b0, ok);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    byte_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (wa.size() !== 1 || (wa.size() > 0 && wd[0] !== exp_q[0])) begin
      miscompares++;
      $display("FAIL abort_writes: got %0d writes, want 1 of %h",
               wa.size(), exp_q[0]);
    end
    vectors++;
    if ({busy, done, cpu_hold, byte_ready} !== 4'b0010) begin
      miscompares++;
      $display("FAIL abort_state: busy/done/hold/ready=%b, want 0010",
               {busy, done, cpu_hold, byte_ready});
    end
  endtask

  task automatic test_zero_words;
    do_start(0);
    @(negedge clk);
    vectors++;
    if ({done, busy, cpu_hold, len_err} !== 4'b1000 || wa.size() != 0) begin
      miscompares++;
      $display("FAIL zero_words: done/busy/hold/lerr=%b writes=%0d, want 1000 and 0",
               {done, busy, cpu_hold, len_err}, wa.size());
    end
  endtask

  task automatic test_abort_in_done;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    vectors++;
    if ({done, cpu_hold} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_in_done: done/hold=%b, want 10", {done, cpu_hold});
    end
  endtask

  task automatic test_reset_midload;
    bit ok;
    do_start(2);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b0, ok);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, cpu_hold, byte_ready, mem_we, mem_addr} !== 18'h08000) begin
      miscompares++;
      $display("FAIL reset_midload: busy/done/hold/ready/we=%b addr=%h, want 00100 0",
               {busy, done, cpu_hold, byte_ready, mem_we}, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clamp;
    bit ok;
    int bad;
    bad = 0;
    exp_q.delete();
    for (int i = 0; i < 8192; i++) exp_q.push_back($urandom);
    run_load(9000, 1'b0, 32'd0, ok);
    vectors++;
    if (!ok || len_err !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp_lerr: ok=%b len_err=%b, want 1 1", ok, len_err);
    end
    vectors++;
    if (wa.size() !== 8192) begin
      miscompares++;
      $display("FAIL clamp_count: got %0d writes, want 8192", wa.size());
    end
    foreach (exp_q[i]) begin
      if (i < wa.size() && (wa[i] !== 13'(i) || wd[i] !== exp_q[i])) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL clamp_data: %0d bad writes, want 0", bad);
    end
    vectors++;
    if (mem_addr !== 13'h1FFF || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_last: addr=%h hold=%b, want 1fff 0", mem_addr,
               cpu_hold);
    end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum;
    bit ok;
    exp_q.delete();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    run_load(2, 1'b1, 32'd0, ok);
    vectors++;
    if (!ok || {done, chk_err, cpu_hold} !== 3'b100) begin
      miscompares++;
      $display("FAIL chk_good: ok=%b done/cerr/hold=%b, want 1 100", ok,
               {done, chk_err, cpu_hold});
    end
    run_load(2, 1'b0, 32'd1, ok);
    vectors++;
    if (!ok || {done, chk_err, cpu_hold} !== 3'b111) begin
      miscompares++;
      $display("FAIL chk_bad: ok=%b done/cerr/hold=%b, want 1 111", ok,
               {done, chk_err, cpu_hold});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load("basic", 2, 1'b0, 1'b1);
    test_load("backpressure", 2, 1'b1, 1'b1);
    test_abort();
    test_zero_words();
    test_abort_in_done();
    test_reset_midload();
    for (int r = 0; r < 4; r++) begin
      test_load("random", $urandom_range(1, 6), 1'b1, 1'b0);
    end
    test_clamp();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
